// File: rtl/seq_sub_pkg.sv
// Shared types and constants for the chunked sequential subtractor.
// Used by seq_sub_16b and sub_chunk_4b.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_e;

  localparam int CHUNK     = 4;
  localparam int N_DEFAULT = 16;
  localparam int STEPS     = N_DEFAULT / CHUNK;
  localparam int CNT_W     = $clog2(STEPS);

endpackage

// File: rtl/sub_chunk_4b.sv
// Combinational CHUNK-bit adder slice; invert_b with c_in=1 turns it into a subtractor.
// Shared across all steps of seq_sub_16b.
module sub_chunk_4b
  import seq_sub_pkg::*;
#(
  parameter int W = seq_sub_pkg::CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         invert_b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out
);

  logic [W-1:0] bSel;
  logic [W:0]   total;

  always_comb begin
    bSel  = invert_b ? ~b : b;
    total = {1'b0, a} + {1'b0, bSel} + {{W{1'b0}}, c_in};
    s     = total[W-1:0];
    c_out = total[W];
  end

endmodule

// File: rtl/seq_sub_16b.sv
// Multi-cycle N-bit subtractor, one CHUNK per clock through a registered carry.
// Optional macro SEQ_SUB_ADD_SEL_EN adds an op_add input selecting A + B instead of A - B.
module seq_sub_16b
  import seq_sub_pkg::*;
#(
  parameter int N     = seq_sub_pkg::N_DEFAULT,
  parameter int CHUNK = seq_sub_pkg::CHUNK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
`ifdef SEQ_SUB_ADD_SEL_EN
  input  logic         op_add,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         borrow_out,
  output logic         ovf,
  output logic         zero
);

  localparam int NSTEPS = N / CHUNK;
  localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    d_q;
  logic [N-1:0]    d_d;
  logic            carry_q;
  logic            borrow_q;
  logic            ovf_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;
  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK-1:0] sum;
  logic            cOut;
  logic            invB;
  logic            borrow_d;
  logic            ovf_d;
  logic            isAdd;
  logic            initCarry;
  int unsigned     base;
`ifdef SEQ_SUB_ADD_SEL_EN
  logic            op_add_q;
`endif

`ifdef SEQ_SUB_ADD_SEL_EN
  assign isAdd     = op_add_q;
  assign initCarry = ~op_add;
`else
  assign isAdd     = 1'b0;
  assign initCarry = 1'b1;
`endif

  // The chunk result is merged into the full word here so the final-step flags see the whole difference.
  always_comb begin
    base     = int'(cnt_q) * CHUNK;
    aChunk   = a_q[base +: CHUNK];
    bChunk   = b_q[base +: CHUNK];
    invB     = ~isAdd;
    d_d      = d_q;
    d_d[base +: CHUNK] = sum;
    borrow_d = isAdd ? cOut : ~cOut;
    if (isAdd)
      ovf_d = (a_q[N-1] == b_q[N-1]) & (d_d[N-1] != a_q[N-1]);
    else
      ovf_d = (a_q[N-1] != b_q[N-1]) & (d_d[N-1] != a_q[N-1]);
  end

  sub_chunk_4b #(.W(CHUNK)) u_chunk (
    .a       (aChunk),
    .b       (bChunk),
    .invert_b(invB),
    .c_in    (carry_q),
    .s       (sum),
    .c_out   (cOut)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_SUB_ADD_SEL_EN
      op_add_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            carry_q  <= initCarry;
            cnt_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= STEP;
`ifdef SEQ_SUB_ADD_SEL_EN
            op_add_q <= op_add;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        STEP: begin
          d_q     <= d_d;
          carry_q <= cOut;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= (d_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign D          = d_q;
  assign borrow_out = borrow_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_seq_sub_16b.sv
// Directed self-checking bench for seq_sub_16b (default build, subtract only).
module tb_seq_sub_16b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] D;
  logic        borrow_out;
  logic        ovf;
  logic        zero;

  int checks;
  int failures;

  seq_sub_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
`ifdef SEQ_SUB_ADD_SEL_EN
    .op_add    (1'b0),
`endif
    .busy      (busy),
    .done      (done),
    .D         (D),
    .borrow_out(borrow_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start across exactly one rising edge; returns at the following falling edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busyCnt, output bit ok);
    busyCnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busyCnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    A = 16'h0;
    B = 16'h0;
    #12;
    checks++;
    if ({busy, done, D, borrow_out, ovf, zero} !== 21'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=0", {busy, done, D, borrow_out, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, D} !== 18'h0) begin
      failures++;
      $display("[TB] FAIL idle_hold got=%h want=0", {busy, done, D});
    end
  endtask

  task automatic test_subtract();
    logic [15:0] va[6]  = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h0000, 16'hA5A5};
    logic [15:0] vb[6]  = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h0001, 16'h5A5A};
    logic [15:0] vd[6]  = '{16'h0002, 16'hFFFE, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h4B4B};
    logic [2:0]  vf[6]  = '{3'b000,   3'b100,   3'b010,   3'b110,   3'b100,   3'b010};
    int busyCnt;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i]);
      wait_done(busyCnt, ok);
      checks++;
      if (!ok || busyCnt != 4) begin
        failures++;
        $display("[TB] FAIL latency vec%0d busy_cycles=%0d done_seen=%0d want 4/1", i, busyCnt, ok);
      end
      checks++;
      if (D !== vd[i]) begin
        failures++;
        $display("[TB] FAIL diff vec%0d got=%h want=%h", i, D, vd[i]);
      end
      checks++;
      if ({borrow_out, ovf, zero} !== vf[i]) begin
        failures++;
        $display("[TB] FAIL flags vec%0d got=%b want=%b", i, {borrow_out, ovf, zero}, vf[i]);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || D !== vd[i] || {borrow_out, ovf, zero} !== vf[i]) begin
        failures++;
        $display("[TB] FAIL hold vec%0d done=%b busy=%b D=%h flags=%b want 0/0/%h/%b",
                 i, done, busy, D, {borrow_out, ovf, zero}, vd[i], vf[i]);
      end
    end
  endtask

  task automatic test_zero_and_back_to_back();
    int busyCnt;
    bit ok;
    start_op(16'h1234, 16'h1234);
    wait_done(busyCnt, ok);
    checks++;
    if (!ok || D !== 16'h0000 || {borrow_out, ovf, zero} !== 3'b001) begin
      failures++;
      $display("[TB] FAIL equal_operands done=%b D=%h flags=%b want 1/0000/001", ok, D, {borrow_out, ovf, zero});
    end
    A = 16'h0010;
    B = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_accept busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(busyCnt, ok);
    checks++;
    if (!ok || busyCnt != 4 || D !== 16'h000F || {borrow_out, ovf, zero} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL b2b_result done=%b busy_cycles=%0d D=%h flags=%b want 1/4/000F/000",
               ok, busyCnt, D, {borrow_out, ovf, zero});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [15:0] dSeen;
    pulses = 0;
    dSeen = 16'hDEAD;
    start_op(16'h0100, 16'h0001);
    A = 16'hFFFF;
    B = 16'h0002;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        dSeen = D;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("[TB] FAIL ignore_start_pulses got=%0d want=1", pulses);
    end
    checks++;
    if (dSeen !== 16'h00FF) begin
      failures++;
      $display("[TB] FAIL ignore_start_result got=%h want=00FF", dSeen);
    end
  endtask

  task automatic test_async_reset();
    int busyCnt;
    bit ok;
    start_op(16'h5555, 16'h1111);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || D[3:0] !== 4'h4) begin
      failures++;
      $display("[TB] FAIL mid_op busy=%b D_low=%h want 1/4", busy, D[3:0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, D, borrow_out, ovf, zero} !== 21'h0) begin
      failures++;
      $display("[TB] FAIL async_abort got=%h want=0", {busy, done, D, borrow_out, ovf, zero});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h5555, 16'h1111);
    wait_done(busyCnt, ok);
    checks++;
    if (!ok || busyCnt != 4 || D !== 16'h4444 || {borrow_out, ovf, zero} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL post_reset done=%b busy_cycles=%0d D=%h flags=%b want 1/4/4444/000",
               ok, busyCnt, D, {borrow_out, ovf, zero});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_subtract();
    test_zero_and_back_to_back();
    test_start_ignored();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
